tcam_lookup_stage: RTL and testbench
====================================

# tcam_lookup_stage

Key-match stage that feeds the TCAM-to-action pipeline register: it holds a 16-entry ternary match table, accepts lookup keys over a valid/ready handshake and drives `tcam_valid`/`tcam_hit`/`tcam_hit_index` towards the downstream pipe, honouring its `tcam_ready` backpressure. The stage also provides a table-programming port and saturating hit/miss statistics counters.

## Interface
- `KEY_W`, default 32, lookup key and per-entry key/mask width
- `CNT_W`, default 16, width of hit/miss statistics counters
- Entry count fixed at 16; index width fixed at 4.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `key_valid`  in  1  lookup key presented
- `key_ready`  out  1  stage can accept a key this cycle
- `key`  in  KEY_W  lookup key
- `wr_en`  in  1  program one table entry this cycle
- `wr_index`  in  4  entry to program
- `wr_key`  in  KEY_W  entry match value
- `wr_mask`  in  KEY_W  entry care mask (1 = bit compared, 0 = don't care)
- `wr_entry_valid`  in  1  entry enable written alongside key/mask
- `tcam_valid`  out  1  result held for downstream
- `tcam_ready`  in  1  downstream accepts result
- `tcam_hit`  out  1  at least one enabled entry matched
- `tcam_hit_index`  out  4  lowest matching index; 0 on miss
- `clr_counters`  in  1  synchronous clear of statistics
- `hit_count`  out  CNT_W  accepted lookups that hit
- `miss_count`  out  CNT_W  accepted lookups that missed

## Operation
- Entry i matches when enabled and `((key ^ entry_key[i]) & entry_mask[i]) == 0`.
- Priority: lowest matching index wins; all-zero mask on an enabled entry matches every key.
- Accept: `key_valid && key_ready`. On accept, the match result for `key` is registered into `tcam_hit`/`tcam_hit_index` and `tcam_valid` is set.
- `key_ready = !tcam_valid || tcam_ready`. This gives full throughput: a new result may be loaded in the same cycle the old one is consumed.
- Consume: `tcam_valid && tcam_ready` with no new accept clears `tcam_valid`.
- Stall: while `tcam_valid && !tcam_ready`, `tcam_hit`/`tcam_hit_index` stay stable and `key_ready` = 0.
- Programming: on `wr_en`, entry `wr_index` takes `wr_key`, `wr_mask` and `wr_entry_valid` at the clock edge. Programming is independent of the handshake and never stalls it.
- Write/lookup collision in the same cycle: the lookup uses the table contents from before the write; the written entry is effective from the next accept.
- Counters: on each accept, `hit_count` is incremented on a hit and `miss_count` on a miss. Both saturate at all-ones.
- `clr_counters` zeroes both counters. It wins over a simultaneous increment, so the counter reads 0 afterwards.
- Miss result: `tcam_hit` = 0, `tcam_hit_index` = 0.

## Timing
- Reset values:
  - all 16 entries disabled; key/mask reset to 0
  - `tcam_valid` = 0, `tcam_hit` = 0, `tcam_hit_index` = 0
  - `hit_count` = 0, `miss_count` = 0
  - `key_ready` = 1 once reset is deasserted
- Latency: key accepted at edge N gives a result visible with `tcam_valid` = 1 after edge N. Sustained rate is one lookup per cycle while `tcam_ready` = 1.
- Match logic is combinational from `key` and the registered table to the output registers. No output is combinational from `key`.
- `key_ready` is combinational from `tcam_valid` and `tcam_ready` only.
- Reset asserted mid-operation: any pending result is dropped, `tcam_valid` goes to 0 immediately (asynchronous), and the table and counters are cleared.

## Test plan
- Program entry 3 with key 0x0000_AB00, mask 0x0000_FF00, enabled. Look up key 0x1234_AB56 -> `tcam_valid` = 1 the next cycle, hit = 1, index = 3, `hit_count` = 1.
- Enable entries 2 and 9, both with mask 0. Look up any key -> index = 2. Disable entry 2 and repeat -> index = 9. Disable both -> hit = 0, index = 0, `miss_count` increments.
- Hold `tcam_ready` = 0 with a result pending -> `key_ready` = 0 and outputs stable for 5 cycles. Raise `tcam_ready` with `key_valid` = 1 -> the new result loads in the same cycle; there are no bubbles over a 4-key burst.
- Write entry 5 (key 0x55, full mask) and look up 0x55 in the same cycle, table previously empty -> miss. Look up 0x55 again the next cycle -> hit, index = 5.
- With `CNT_W` = 4, perform 20 hit lookups -> `hit_count` = 0xF. Assert `clr_counters` together with an accept -> `hit_count` = 0.
- Assert `rst_n` low while `tcam_valid` = 1 and stalled -> `tcam_valid` = 0 immediately. After release, a lookup on a previously programmed key misses.

Source files
------------

// File: rtl/tcam_lookup_stage.sv
// rtl/tcam_lookup_stage.sv - 16-entry ternary key match stage with result handshake and hit/miss statistics
module tcam_lookup_stage #(
  parameter int KEY_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key,
  input  logic             wr_en,
  input  logic [3:0]       wr_index,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [KEY_W-1:0] wr_mask,
  input  logic             wr_entry_valid,
  output logic             tcam_valid,
  input  logic             tcam_ready,
  output logic             tcam_hit,
  output logic [3:0]       tcam_hit_index,
  input  logic             clr_counters,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int N_ENTRIES = 16;

  logic [KEY_W-1:0]     entry_key_q  [N_ENTRIES];
  logic [KEY_W-1:0]     entry_key_d  [N_ENTRIES];
  logic [KEY_W-1:0]     entry_mask_q [N_ENTRIES];
  logic [KEY_W-1:0]     entry_mask_d [N_ENTRIES];
  logic [N_ENTRIES-1:0] entry_en_q;
  logic [N_ENTRIES-1:0] entry_en_d;

  logic             tcam_valid_q, tcam_valid_d;
  logic             tcam_hit_q, tcam_hit_d;
  logic [3:0]       tcam_hit_index_q, tcam_hit_index_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic       accept;
  logic       match_hit;
  logic [3:0] match_index;

  assign key_ready = !tcam_valid_q || tcam_ready;
  assign accept    = key_valid && key_ready;

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      entry_key_d[i]  = entry_key_q[i];
      entry_mask_d[i] = entry_mask_q[i];
    end
    entry_en_d = entry_en_q;
    if (wr_en) begin
      entry_key_d[wr_index]  = wr_key;
      entry_mask_d[wr_index] = wr_mask;
      entry_en_d[wr_index]   = wr_entry_valid;
    end
  end

  // Scan from the top so the lowest matching index is the last one written.
  // Only the registered table is used, so a same-cycle write is not seen here.
  always_comb begin
    match_hit   = 1'b0;
    match_index = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (entry_en_q[i] && (((key ^ entry_key_q[i]) & entry_mask_q[i]) == '0)) begin
        match_hit   = 1'b1;
        match_index = 4'(i);
      end
    end
  end

  always_comb begin
    tcam_valid_d     = tcam_valid_q;
    tcam_hit_d       = tcam_hit_q;
    tcam_hit_index_d = tcam_hit_index_q;
    if (accept) begin
      tcam_valid_d     = 1'b1;
      tcam_hit_d       = match_hit;
      tcam_hit_index_d = match_index;
    end else if (tcam_ready) begin
      tcam_valid_d = 1'b0;
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (clr_counters) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else if (accept) begin
      if (match_hit) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        entry_key_q[i]  <= '0;
        entry_mask_q[i] <= '0;
      end
      entry_en_q       <= '0;
      tcam_valid_q     <= 1'b0;
      tcam_hit_q       <= 1'b0;
      tcam_hit_index_q <= '0;
      hit_count_q      <= '0;
      miss_count_q     <= '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        entry_key_q[i]  <= entry_key_d[i];
        entry_mask_q[i] <= entry_mask_d[i];
      end
      entry_en_q       <= entry_en_d;
      tcam_valid_q     <= tcam_valid_d;
      tcam_hit_q       <= tcam_hit_d;
      tcam_hit_index_q <= tcam_hit_index_d;
      hit_count_q      <= hit_count_d;
      miss_count_q     <= miss_count_d;
    end
  end

  assign tcam_valid     = tcam_valid_q;
  assign tcam_hit       = tcam_hit_q;
  assign tcam_hit_index = tcam_hit_index_q;
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_tcam_lookup_stage.sv
// tb/tb_tcam_lookup_stage.sv - scoreboard bench for tcam_lookup_stage with a table-level reference model
module tb_tcam_lookup_stage;
  localparam int KEY_W = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key;
  logic             wr_en;
  logic [3:0]       wr_index;
  logic [KEY_W-1:0] wr_key;
  logic [KEY_W-1:0] wr_mask;
  logic             wr_entry_valid;
  logic             tcam_valid;
  logic             tcam_ready;
  logic             tcam_hit;
  logic [3:0]       tcam_hit_index;
  logic             clr_counters;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  tcam_lookup_stage #(.KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .wr_en(wr_en), .wr_index(wr_index), .wr_key(wr_key), .wr_mask(wr_mask),
    .wr_entry_valid(wr_entry_valid),
    .tcam_valid(tcam_valid), .tcam_ready(tcam_ready), .tcam_hit(tcam_hit),
    .tcam_hit_index(tcam_hit_index), .clr_counters(clr_counters),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } res_t;

  res_t     sb[$];
  bit [31:0] m_key [16];
  bit [31:0] m_mask[16];
  bit        m_en  [16];
  int        m_hits, m_misses;
  int        n_cmp, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t m_lookup(input bit [31:0] k);
    int hits[$];
    res_t r;
    for (int i = 0; i < 16; i++)
      if (m_en[i] && ((k & m_mask[i]) == (m_key[i] & m_mask[i]))) hits.push_back(i);
    r.hit = (hits.size() != 0);
    r.idx = r.hit ? 4'(hits.min()[0]) : 4'd0;
    return r;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_key[i] = '0; m_mask[i] = '0; m_en[i] = 1'b0;
    end
    m_hits = 0; m_misses = 0;
    sb.delete();
  endfunction

  // Monitor: compare the held result whenever one is presented; retire it when consumed.
  always @(negedge clk) begin
    if (rst_n && tcam_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(tcam_valid), 32'd0);
      end else begin
        check("tcam_hit", 32'(tcam_hit), 32'(sb[0].hit));
        check("tcam_hit_index", 32'(tcam_hit_index), 32'(sb[0].idx));
        if (tcam_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input bit kv, input bit [31:0] k, input bit we, input bit [3:0] wi,
                      input bit [31:0] wk, input bit [31:0] wm, input bit wen,
                      input bit rdy, input bit clr);
    bit exp_ready;
    key_valid = kv; key = k; wr_en = we; wr_index = wi; wr_key = wk; wr_mask = wm;
    wr_entry_valid = wen; tcam_ready = rdy; clr_counters = clr;
    #1;
    exp_ready = (sb.size() == 0) || rdy;
    check("key_ready", 32'(key_ready), 32'(exp_ready));
    if (kv && exp_ready) begin
      res_t r;
      r = m_lookup(k);
      sb.push_back(r);
      if (r.hit) m_hits = (m_hits == CNT_MAX) ? CNT_MAX : m_hits + 1;
      else       m_misses = (m_misses == CNT_MAX) ? CNT_MAX : m_misses + 1;
    end
    if (clr) begin
      m_hits = 0; m_misses = 0;
    end
    if (we) begin
      m_key[wi] = wk; m_mask[wi] = wm; m_en[wi] = wen;
    end
    @(posedge clk);
    #1;
    check("hit_count", 32'(hit_count), 32'(m_hits));
    check("miss_count", 32'(miss_count), 32'(m_misses));
    check("tcam_valid", 32'(tcam_valid), 32'(sb.size() != 0));
  endtask

  task automatic write_entry(input bit [3:0] wi, input bit [31:0] wk, input bit [31:0] wm, input bit wen);
    step(1'b0, 32'd0, 1'b1, wi, wk, wm, wen, 1'b1, 1'b0);
  endtask

  task automatic lookup(input bit [31:0] k);
    step(1'b1, k, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clear_table();
    for (int i = 0; i < 16; i++) write_entry(4'(i), 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    bit [31:0] masks[4];
    masks[0] = 32'h0; masks[1] = 32'hF; masks[2] = 32'h3; masks[3] = 32'hFFFF_FFFF;
    n_cmp = 0; n_fail = 0;
    m_reset();
    rst_n = 1'b0; key_valid = 1'b0; key = '0; wr_en = 1'b0; wr_index = '0; wr_key = '0;
    wr_mask = '0; wr_entry_valid = 1'b0; tcam_ready = 1'b1; clr_counters = 1'b0;
    #2;
    check("rst_tcam_valid", 32'(tcam_valid), 32'd0);
    check("rst_tcam_hit", 32'(tcam_hit), 32'd0);
    check("rst_hit_index", 32'(tcam_hit_index), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_key_ready", 32'(key_ready), 32'd1);

    // Basic masked hit
    write_entry(4'd3, 32'h0000_AB00, 32'h0000_FF00, 1'b1);
    lookup(32'h1234_AB56);
    idle();
    check("basic_hit_count", 32'(hit_count), 32'd1);

    // Priority between two wildcard entries, then disable
    clear_table();
    write_entry(4'd2, 32'h0, 32'h0, 1'b1);
    write_entry(4'd9, 32'h0, 32'h0, 1'b1);
    lookup(32'hDEAD_BEEF);
    write_entry(4'd2, 32'h0, 32'h0, 1'b0);
    lookup(32'h0BAD_F00D);
    write_entry(4'd9, 32'h0, 32'h0, 1'b0);
    lookup(32'h1357_9BDF);
    idle();

    // Stall for 5 cycles, then a 4-key burst with no bubbles
    write_entry(4'd7, 32'h0000_0010, 32'h0000_00F0, 1'b1);
    step(1'b1, 32'h11, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h22, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) lookup(32'h10 + 32'(i * 8));
    idle();

    // Write and lookup to the same entry in one cycle
    clear_table();
    step(1'b1, 32'h55, 1'b1, 4'd5, 32'h55, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    lookup(32'h55);
    idle();

    // Counter saturation and clear winning over an accept
    write_entry(4'd0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) lookup($urandom());
    check("hit_count_saturated", 32'(hit_count), 32'(CNT_MAX));
    step(1'b1, 32'h1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    check("hit_count_cleared", 32'(hit_count), 32'd0);
    idle();

    // Randomized traffic
    clear_table();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
           32'($urandom_range(0, 15)), masks[$urandom_range(0, 3)],
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0);
    end
    idle();

    // Asynchronous reset while a result is stalled
    clear_table();
    write_entry(4'd4, 32'hCAFE, 32'hFFFF, 1'b1);
    step(1'b1, 32'hCAFE, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("async_rst_tcam_valid", 32'(tcam_valid), 32'd0);
    check("async_rst_key_ready", 32'(key_ready), 32'd1);
    check("async_rst_hit_count", 32'(hit_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    lookup(32'hCAFE);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
